// File: rtl/div19s_by8s_pkg.sv
// Shared constants, state encoding and saturation limits for the signed 19/8 divider.
package div_pkg;

    localparam int WN = 19;
    localparam int WD = 8;
    localparam int WQ = 11;

    localparam int QMAX = 1023;
    localparam int QMIN = -1024;

    // Limits at the width of the signed quotient before saturation
    localparam logic signed [WN:0] QMAX_S = QMAX[WN:0];
    localparam logic signed [WN:0] QMIN_S = QMIN[WN:0];

    localparam logic [4:0] CNT_LAST = 5'(WN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        FIX  = 2'd3
    } state_t;

endpackage

// File: rtl/div19s_by8s_udiv_step.sv
// One restoring shift-subtract step on unsigned magnitudes.
module udiv_step
    import div_pkg::*;
(
    input  logic [WD:0] i_rem,
    input  logic        i_bit,
    input  logic [WD:0] i_dvs,
    output logic [WD:0] o_rem,
    output logic        o_qbit
);

    logic [WD+1:0] w_trial;
    logic [WD:0]   w_diff;

    assign w_trial = {i_rem, i_bit};
    // The true difference is below |divisor| whenever it is taken, so 9 bits suffice
    assign w_diff  = w_trial[WD:0] - i_dvs;
    assign o_qbit  = (w_trial >= {1'b0, i_dvs});
    assign o_rem   = o_qbit ? w_diff : w_trial[WD:0];

endmodule

// File: rtl/div19s_by8s.sv
// Sequential signed divider: 19-bit dividend / 8-bit divisor -> 11-bit saturated quotient, 8-bit remainder.
// Handshake: start is sampled only while busy=0; busy spans accept edge to done edge; done pulses one cycle.
module div19s_by8s
    import div_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [WN-1:0] dividend,
    input  logic [WD-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [WQ-1:0] quotient,
    output logic [WD-1:0] remainder,
    output logic          ovf,
    output logic          dbz,
    output logic [1:0]    dbg_state
);

    state_t        r_state;
    logic          r_busy, r_done, r_ovf, r_dbz;
    logic          r_sign_q, r_sign_r;
    logic [WQ-1:0] r_quot;
    logic [WD-1:0] r_rem_out;
    logic [WN-1:0] r_dividend, r_num, r_qmag;
    logic [WD-1:0] r_divisor;
    logic [WD:0]   r_dvs, r_prem;
    logic [4:0]    r_cnt;

    logic signed [WN:0] w_ext_n, w_abs_n, w_q_signed;
    logic signed [WD:0] w_ext_d, w_abs_d;
    logic [WD-1:0]      w_r_signed;
    logic [WD:0]        w_step_rem;
    logic               w_step_q;

    assign w_ext_n = {r_dividend[WN-1], r_dividend};
    assign w_abs_n = w_ext_n[WN] ? -w_ext_n : w_ext_n;
    assign w_ext_d = {r_divisor[WD-1], r_divisor};
    assign w_abs_d = w_ext_d[WD] ? -w_ext_d : w_ext_d;

    assign w_q_signed = r_sign_q ? -$signed({1'b0, r_qmag}) : $signed({1'b0, r_qmag});
    assign w_r_signed = r_sign_r ? -r_prem[WD-1:0] : r_prem[WD-1:0];

    udiv_step u_step (
        .i_rem  (r_prem),
        .i_bit  (r_num[WN-1]),
        .i_dvs  (r_dvs),
        .o_rem  (w_step_rem),
        .o_qbit (w_step_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_dbz      <= 1'b0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_quot     <= '0;
            r_rem_out  <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_num      <= '0;
            r_qmag     <= '0;
            r_dvs      <= '0;
            r_prem     <= '0;
            r_cnt      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_dividend <= dividend;
                        r_divisor  <= divisor;
                        r_busy     <= 1'b1;
                        r_state    <= LOAD;
                    end
                end
                LOAD: begin
                    // Top bit of |dividend| is always 0; it seeds the partial remainder
                    r_num    <= w_abs_n[WN-1:0];
                    r_prem   <= {{WD{1'b0}}, w_abs_n[WN]};
                    r_dvs    <= w_abs_d;
                    r_sign_q <= r_dividend[WN-1] ^ r_divisor[WD-1];
                    r_sign_r <= r_dividend[WN-1];
                    r_qmag   <= '0;
                    r_cnt    <= '0;
                    r_state  <= ITER;
                end
                ITER: begin
                    r_prem <= w_step_rem;
                    r_num  <= {r_num[WN-2:0], 1'b0};
                    r_qmag <= {r_qmag[WN-2:0], w_step_q};
                    r_cnt  <= r_cnt + 5'd1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    if (r_divisor == '0) begin
                        r_quot    <= '0;
                        r_rem_out <= '0;
                        r_ovf     <= 1'b0;
                        r_dbz     <= 1'b1;
                    end else begin
                        r_dbz     <= 1'b0;
                        r_rem_out <= w_r_signed;
                        if (w_q_signed > QMAX_S) begin
                            r_quot <= QMAX_S[WQ-1:0];
                            r_ovf  <= 1'b1;
                        end else if (w_q_signed < QMIN_S) begin
                            r_quot <= QMIN_S[WQ-1:0];
                            r_ovf  <= 1'b1;
                        end else begin
                            r_quot <= w_q_signed[WQ-1:0];
                            r_ovf  <= 1'b0;
                        end
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign quotient  = r_quot;
    assign remainder = r_rem_out;
    assign ovf       = r_ovf;
    assign dbz       = r_dbz;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_div19s_by8s.sv
// Bench for div19s_by8s: table vectors, random vectors against a behavioural model, handshake corner cases.
module tb_div19s_by8s;
  import div_pkg::*;

  localparam int RW = 21;  // {quotient, remainder, ovf, dbz}

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [18:0] dividend;
  logic [7:0]  divisor;
  logic        busy, done, ovf, dbz;
  logic [10:0] quotient;
  logic [7:0]  remainder;
  logic [1:0]  dbg_state;

  div19s_by8s dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf),
    .dbz       (dbz),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  int            acc_q[$];
  int            checks = 0;
  int            failures = 0;
  int            done_count = 0;
  logic [RW-1:0] m_exp;
  int            m_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      done_count++;
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'(done), 32'd0);
      end else begin
        m_exp = exp_q.pop_front();
        m_acc = acc_q.pop_front();
        check("quotient",  32'(quotient),  32'(m_exp[20:10]));
        check("remainder", 32'(remainder), 32'(m_exp[9:2]));
        check("ovf",       32'(ovf),       32'(m_exp[1]));
        check("dbz",       32'(dbz),       32'(m_exp[0]));
        check("latency",   32'(cyc - m_acc), 32'd21);
      end
    end
  end

  // Behavioural reference: integer division truncates toward zero, % takes the dividend's sign
  function automatic logic [RW-1:0] model(input logic [18:0] n, input logic [7:0] d);
    int ni, di, qi, ri;
    logic [10:0] q;
    logic [7:0]  r;
    logic        o;
    ni = int'($signed(n));
    di = int'($signed(d));
    if (di == 0) return {11'd0, 8'd0, 1'b0, 1'b1};
    qi = ni / di;
    ri = ni % di;
    if (qi > 1023) begin
      q = 11'h3FF; o = 1'b1;
    end else if (qi < -1024) begin
      q = 11'h400; o = 1'b1;
    end else begin
      q = qi[10:0]; o = 1'b0;
    end
    r = ri[7:0];
    return {q, r, o, 1'b0};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_div(input logic [18:0] n, input logic [7:0] d, input logic [RW-1:0] e);
    int i;
    i = 0;
    while (busy && i < 60) begin
      @(negedge clk);
      i++;
    end
    check("start_wait_busy", 32'(busy), 32'd0);
    start = 1'b1;
    dividend = n;
    divisor = d;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_on_accept", 32'(busy), 32'd1);
    exp_q.push_back(e);
    acc_q.push_back(cyc);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_done();
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!done && i < 60);
    check("done_timeout", 32'(done), 32'd1);
  endtask

  // ---------------- table ----------------
  typedef struct {
    logic [18:0] n;
    logic [7:0]  d;
    logic [10:0] q;
    logic [7:0]  r;
    logic        o;
    logic        z;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1);
  end

  initial begin
    int base;
    int t_done;
    logic [18:0] rn;
    logic [7:0]  rd;

    vecs[0]  = '{19'h71D39, 8'h55, 11'h555, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{19'h00080, 8'h80, 11'h7FF, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{19'h20000, 8'h80, 11'h400, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{19'h7FFF9, 8'h02, 11'h7FD, 8'hFF, 1'b0, 1'b0};
    vecs[4]  = '{19'h00007, 8'hFE, 11'h7FD, 8'h01, 1'b0, 1'b0};
    vecs[5]  = '{19'h3FFFF, 8'h01, 11'h3FF, 8'h00, 1'b1, 1'b0};
    vecs[6]  = '{19'h40000, 8'h01, 11'h400, 8'h00, 1'b1, 1'b0};
    vecs[7]  = '{19'h12345, 8'h00, 11'h000, 8'h00, 1'b0, 1'b1};
    vecs[8]  = '{19'h40000, 8'h80, 11'h3FF, 8'h00, 1'b1, 1'b0};
    vecs[9]  = '{19'h003FF, 8'h01, 11'h3FF, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{19'h00400, 8'h01, 11'h3FF, 8'h00, 1'b1, 1'b0};
    vecs[11] = '{19'h7FC00, 8'h01, 11'h400, 8'h00, 1'b0, 1'b0};
    vecs[12] = '{19'h0007F, 8'h80, 11'h000, 8'h7F, 1'b0, 1'b0};
    vecs[13] = '{19'h7FF81, 8'h80, 11'h000, 8'h81, 1'b0, 1'b0};

    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_busy",      32'(busy),      32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_quotient",  32'(quotient),  32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    check("rst_dbz",       32'(dbz),       32'd0);
    check("rst_state",     32'(dbg_state), 32'(IDLE));

    // Table vectors, one at a time
    foreach (vecs[i]) begin
      start_div(vecs[i].n, vecs[i].d, {vecs[i].q, vecs[i].r, vecs[i].o, vecs[i].z});
      wait_idle();
    end

    // start while busy is ignored
    base = done_count;
    start_div(19'h71D39, 8'h55, {11'h555, 8'h00, 1'b0, 1'b0});
    repeat (5) @(negedge clk);
    start = 1'b1;
    dividend = 19'h00100;
    divisor = 8'h01;
    @(negedge clk);
    start = 1'b0;
    check("busy_during_ignored_start", 32'(busy), 32'd1);
    wait_idle();
    repeat (25) @(negedge clk);
    check("ignored_start_done_count", 32'(done_count - base), 32'd1);

    // Back-to-back: start in the done cycle
    start_div(19'h7FFF9, 8'h02, {11'h7FD, 8'hFF, 1'b0, 1'b0});
    wait_done();
    t_done = cyc;
    check("done_cycle_busy", 32'(busy), 32'd0);
    start_div(19'h00007, 8'hFE, {11'h7FD, 8'h01, 1'b0, 1'b0});
    wait_done();
    check("b2b_done_spacing", 32'(cyc - t_done), 32'd22);
    wait_idle();

    // Reset in the middle of iteration; outputs currently hold a nonzero result
    start_div(19'h71D39, 8'h55, {11'h555, 8'h00, 1'b0, 1'b0});
    wait_idle();
    start_div(19'h3FFFF, 8'h01, {11'h3FF, 8'h00, 1'b1, 1'b0});
    repeat (11) @(negedge clk);
    check("abort_state_iter", 32'(dbg_state), 32'(ITER));
    base = done_count;
    rst = 1'b1;
    #1;
    check("abort_busy",      32'(busy),      32'd0);
    check("abort_done",      32'(done),      32'd0);
    check("abort_quotient",  32'(quotient),  32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    check("abort_ovf",       32'(ovf),       32'd0);
    check("abort_dbz",       32'(dbz),       32'd0);
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_no_done", 32'(done_count - base), 32'd0);
    check("abort_idle_state", 32'(dbg_state), 32'(IDLE));

    // Random vectors, alternating idle gaps and back-to-back starts
    for (int k = 0; k < 16; k++) begin
      rn = 19'($urandom_range(0, 19'h7FFFF));
      case (k % 4)
        0: rd = 8'($urandom_range(0, 255));
        1: rd = 8'($urandom_range(1, 4));
        2: rd = 8'($urandom_range(8'hF8, 8'hFF));
        default: rd = 8'($urandom_range(8'h7E, 8'h82));
      endcase
      start_div(rn, rd, model(rn, rd));
      if (k % 2 == 1) wait_idle();
      else wait_done();
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
